nios2_jtag_debug_chan_bridge: RTL and testbench

Parametrised successor to the Nios II JTAG debug-module wrapper's system-clock side. It sits between the virtual-JTAG strobes, already synchronised into the system clock domain, and the on-chip debug targets: break, ocimem, trace and further units. It decodes a configurable instruction register into 2**IR_WIDTH channels and captures per-channel status into a shift chain. On update it issues a valid/ready action handshake per channel, flags overrun when a channel is still busy, and replaces the fixed take_action/take_no_action pulses.

---
 rtl/nios2_jtag_debug_chan_bridge.sv | 81 ++++++++
 tb/tb_nios2_jtag_debug_chan_bridge.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2_jtag_debug_chan_bridge.sv
// System-clock side of the Nios II JTAG debug bridge: decodes the virtual-JTAG IR into
// channels, captures per-channel status into a scan chain and issues valid/ready actions.
module nios2_jtag_debug_chan_bridge #(
    parameter int IR_WIDTH = 2,
    parameter int DR_WIDTH = 38,
    localparam int NCH = 2 ** IR_WIDTH,
    localparam int CAP_WIDTH = DR_WIDTH - 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     vs_uir,
    input  logic                     vs_cdr,
    input  logic                     vs_sdr,
    input  logic                     vs_udr,
    input  logic [IR_WIDTH-1:0]      ir_in,
    input  logic                     tdi,
    output logic                     tdo,
    output logic [IR_WIDTH-1:0]      ir_out,
    input  logic [NCH*CAP_WIDTH-1:0] cap_data,
    output logic [DR_WIDTH-1:0]      jdo,
    output logic [NCH-1:0]           act_valid,
    input  logic [NCH-1:0]           act_ready,
    output logic [NCH-1:0]           noact_pulse,
    output logic [NCH-1:0]           overrun
);

    localparam int OVR_BIT = (IR_WIDTH >= 2) ? 1 : 0;

    logic [IR_WIDTH-1:0] ir_reg;
    logic [DR_WIDTH-1:0] sr;

    // Handshake protocol: act_valid[c] rises the cycle after an accepted update and
    // stays high until a cycle with act_valid[c] & act_ready[c]; it then clears on the
    // following edge. act_ready is ignored while act_valid is low. A pending request
    // marks the channel busy, and an action update to a busy channel is dropped and
    // recorded in the sticky overrun flag, which is cleared by capture-DR.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_reg      <= '0;
            sr          <= '0;
            jdo         <= '0;
            act_valid   <= '0;
            noact_pulse <= '0;
            overrun     <= '0;
        end else begin
            noact_pulse <= '0;
            act_valid   <= act_valid & ~act_ready;
            if (vs_uir) begin
                ir_reg <= ir_in;
            end else if (vs_cdr) begin
                sr <= {act_valid[ir_reg], overrun[ir_reg],
                       cap_data[int'(ir_reg)*CAP_WIDTH +: CAP_WIDTH]};
                overrun[ir_reg] <= 1'b0;
            end else if (vs_sdr) begin
                sr <= {tdi, sr[DR_WIDTH-1:1]};
            end else if (vs_udr) begin
                if (sr[DR_WIDTH-1]) begin
                    // Busy uses the registered valid, so a same-cycle ready still overruns.
                    if (act_valid[ir_reg]) begin
                        overrun[ir_reg] <= 1'b1;
                    end else begin
                        jdo                <= sr;
                        act_valid[ir_reg] <= 1'b1;
                    end
                end else begin
                    jdo                  <= sr;
                    noact_pulse[ir_reg] <= 1'b1;
                end
            end
        end
    end

    assign tdo = sr[0];

    always_comb begin
        ir_out    = '0;
        ir_out[0] = act_valid[ir_reg];
        if (IR_WIDTH >= 2) ir_out[OVR_BIT] = overrun[ir_reg];
    end

endmodule

// File: tb/tb_nios2_jtag_debug_chan_bridge.sv
// Bench for nios2_jtag_debug_chan_bridge: directed scenarios then randomized strobes,
// checked against a transaction-level model (bit queue scan chain, per-channel flags).
module tb_nios2_jtag_debug_chan_bridge;

    localparam int IRW  = 2;
    localparam int DRW  = 38;
    localparam int NCH  = 4;
    localparam int CAPW = DRW - 2;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic                  vs_uir, vs_cdr, vs_sdr, vs_udr;
    logic [IRW-1:0]        ir_in;
    logic                  tdi;
    logic                  tdo;
    logic [IRW-1:0]        ir_out;
    logic [NCH*CAPW-1:0]   cap_data;
    logic [DRW-1:0]        jdo;
    logic [NCH-1:0]        act_valid;
    logic [NCH-1:0]        act_ready;
    logic [NCH-1:0]        noact_pulse;
    logic [NCH-1:0]        overrun;

    nios2_jtag_debug_chan_bridge #(.IR_WIDTH(IRW), .DR_WIDTH(DRW)) dut (
        .clk(clk), .reset_n(reset_n),
        .vs_uir(vs_uir), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_udr(vs_udr),
        .ir_in(ir_in), .tdi(tdi), .tdo(tdo), .ir_out(ir_out),
        .cap_data(cap_data), .jdo(jdo),
        .act_valid(act_valid), .act_ready(act_ready),
        .noact_pulse(noact_pulse), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int             m_ir;
    bit             m_valid[NCH];
    bit             m_ovr[NCH];
    bit             m_sr_q[$];
    logic [DRW-1:0] m_jdo;
    logic [NCH-1:0] m_noact;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ir = 0;
        m_jdo = '0;
        m_noact = '0;
        m_sr_q.delete();
        for (int i = 0; i < DRW; i++) m_sr_q.push_back(1'b0);
        for (int i = 0; i < NCH; i++) begin
            m_valid[i] = 1'b0;
            m_ovr[i]   = 1'b0;
        end
    endtask

    task automatic check_all();
        logic [NCH-1:0] ev, eo;
        for (int i = 0; i < NCH; i++) begin
            ev[i] = m_valid[i];
            eo[i] = m_ovr[i];
        end
        chk("tdo", 64'(tdo), 64'(m_sr_q[0]));
        chk("act_valid", 64'(act_valid), 64'(ev));
        chk("overrun", 64'(overrun), 64'(eo));
        chk("jdo", 64'(jdo), 64'(m_jdo));
        chk("noact_pulse", 64'(noact_pulse), 64'(m_noact));
        chk("ir_out", 64'(ir_out), 64'({eo[m_ir], ev[m_ir]}));
    endtask

    // One clock cycle with the given strobes; model applies the highest-priority strobe.
    task automatic step(input bit u, input bit c, input bit s, input bit d,
                        input logic [IRW-1:0] irv, input bit t, input logic [NCH-1:0] rdy);
        bit             set_v;
        int             ch;
        logic [DRW-1:0] word;
        logic [NCH-1:0] noact_exp;
        vs_uir = u; vs_cdr = c; vs_sdr = s; vs_udr = d;
        ir_in = irv; tdi = t; act_ready = rdy;
        ch = m_ir;
        set_v = 1'b0;
        noact_exp = '0;
        if (u) begin
            m_ir = int'(irv);
        end else if (c) begin
            m_sr_q.delete();
            for (int i = 0; i < CAPW; i++) m_sr_q.push_back(cap_data[ch*CAPW + i]);
            m_sr_q.push_back(m_ovr[ch]);
            m_sr_q.push_back(m_valid[ch]);
            m_ovr[ch] = 1'b0;
        end else if (s) begin
            void'(m_sr_q.pop_front());
            m_sr_q.push_back(t);
        end else if (d) begin
            for (int i = 0; i < DRW; i++) word[i] = m_sr_q[i];
            if (word[DRW-1]) begin
                if (m_valid[ch]) m_ovr[ch] = 1'b1;
                else begin
                    m_jdo = word;
                    set_v = 1'b1;
                end
            end else begin
                m_jdo = word;
                noact_exp[ch] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        vs_uir = 0; vs_cdr = 0; vs_sdr = 0; vs_udr = 0;
        act_ready = '0;
        for (int i = 0; i < NCH; i++) if (rdy[i]) m_valid[i] = 1'b0;
        if (set_v) m_valid[ch] = 1'b1;
        m_noact = noact_exp;
        check_all();
    endtask

    task automatic idle(input logic [NCH-1:0] rdy);
        step(0, 0, 0, 0, '0, 0, rdy);
    endtask

    task automatic do_uir(input logic [IRW-1:0] v);
        step(1, 0, 0, 0, v, 0, '0);
    endtask

    task automatic do_cdr();
        step(0, 1, 0, 0, '0, 0, '0);
    endtask

    task automatic do_udr(input logic [NCH-1:0] rdy);
        step(0, 0, 0, 1, '0, 0, rdy);
    endtask

    task automatic shift_word(input logic [DRW-1:0] w);
        for (int i = 0; i < DRW; i++) step(0, 0, 1, 0, '0, w[i], '0);
    endtask

    // Capture then shift out all bits, recording tdo LSB first.
    task automatic capture_read(output logic [DRW-1:0] bits);
        do_cdr();
        bits[0] = tdo;
        for (int i = 1; i < DRW; i++) begin
            step(0, 0, 1, 0, '0, 1'($urandom_range(0, 1)), '0);
            bits[i] = tdo;
        end
    endtask

    task automatic randomize_cap();
        for (int i = 0; i < NCH*CAPW; i += 32) cap_data[i +: 32] = 32'($urandom);
    endtask

    logic [DRW-1:0] bits;

    initial begin
        reset_n = 1'b0;
        vs_uir = 0; vs_cdr = 0; vs_sdr = 0; vs_udr = 0;
        ir_in = '0; tdi = 0; act_ready = '0; cap_data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tdo", 64'(tdo), 64'd0);
        chk("reset_act_valid", 64'(act_valid), 64'd0);
        chk("reset_jdo", 64'(jdo), 64'd0);
        chk("reset_ir_out", 64'(ir_out), 64'd0);
        check_all();
        @(negedge clk);
        reset_n = 1'b1;

        // Capture on channel 2 and shift out
        cap_data[2*CAPW +: CAPW] = 36'h9_ABCD_1234;
        do_uir(2);
        capture_read(bits);
        chk("capture_ch2", 64'(bits), 64'({2'b00, 36'h9_ABCD_1234}));

        // Action on channel 1 with delayed ready
        do_uir(1);
        shift_word(38'h20_0000_0055);
        do_udr('0);
        chk("accept_valid", 64'(act_valid), 64'(4'b0010));
        chk("accept_jdo", 64'(jdo), 64'(38'h20_0000_0055));
        repeat (5) idle('0);
        chk("valid_held", 64'(act_valid), 64'(4'b0010));
        idle(4'b0010);
        chk("valid_cleared", 64'(act_valid), 64'd0);

        // Overrun on busy channel 1, then clear-on-read
        shift_word(38'h20_0000_00AA);
        do_udr('0);
        shift_word(38'h3F_FFFF_FFFF);
        do_udr('0);
        chk("overrun_set", 64'(overrun[1]), 64'd1);
        chk("overrun_jdo_kept", 64'(jdo), 64'(38'h20_0000_00AA));
        chk("overrun_ir_out", 64'(ir_out), 64'(2'b11));
        capture_read(bits);
        chk("capture_status", 64'(bits[DRW-1:DRW-2]), 64'(2'b11));
        chk("overrun_cleared", 64'(overrun[1]), 64'd0);
        idle(4'b0010);

        // No-action update on channel 3
        do_uir(3);
        shift_word(38'h1A_5A5A_5A5A);
        do_udr('0);
        chk("noact_pulse", 64'(noact_pulse), 64'(4'b1000));
        chk("noact_valid", 64'(act_valid), 64'd0);
        idle('0);
        chk("noact_one_cycle", 64'(noact_pulse), 64'd0);

        // Update on channel 0 in the same cycle as its handshake completes
        do_uir(0);
        shift_word(38'h20_0000_0001);
        do_udr('0);
        shift_word(38'h20_0000_0002);
        do_udr(4'b0001);
        chk("race_overrun", 64'(overrun[0]), 64'd1);
        chk("race_valid", 64'(act_valid[0]), 64'd0);
        chk("race_jdo", 64'(jdo), 64'(38'h20_0000_0001));

        // Asynchronous reset with two pending actions
        do_uir(1);
        shift_word(38'h20_0000_0011);
        do_udr('0);
        do_uir(2);
        shift_word(38'h20_0000_0022);
        do_udr('0);
        chk("pending_two", 64'(act_valid), 64'(4'b0110));
        #2 reset_n = 1'b0;
        #1;
        chk("async_act_valid", 64'(act_valid), 64'd0);
        chk("async_overrun", 64'(overrun), 64'd0);
        chk("async_jdo", 64'(jdo), 64'd0);
        chk("async_ir_out", 64'(ir_out), 64'd0);
        chk("async_tdo", 64'(tdo), 64'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        idle('0);

        // Randomized strobes, including overlapping ones
        for (int n = 0; n < 3000; n++) begin
            randomize_cap();
            step($urandom_range(0, 11) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0,
                 IRW'($urandom_range(0, NCH-1)), 1'($urandom_range(0, 1)),
                 NCH'($urandom & $urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
